bram_stream_reader: RTL

//   Read-side master for the bram block. On a start command it issues rd_en/rd_add
//   to the BRAM read port for a block of consecutive words and absorbs the 1-cycle

---
 rtl/bram_stream_reader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/bram_stream_reader.sv
// Read-side master for a single-port BRAM: streams a block of consecutive words
// onto a valid/ready interface, hiding the one-cycle read latency behind a 2-entry buffer.
module bram_stream_reader #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_add,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_add,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WIDTH-1:0]  m_data,
    output logic              m_last
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cmd_cnt;
    logic [CNT_W-1:0]  issued;
    logic [ADDR_W-1:0] ptr;
    logic              inflight;
    logic              inflight_last;
    logic [1:0]        occ;
    logic [WIDTH-1:0]  buf_data;
    logic              buf_last;

    logic              pop;
    logic              push;
    logic              credit_ok;
    logic [CNT_W-1:0]  count_clamped;
    logic [ADDR_W-1:0] base_mod;

    assign count_clamped = (count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : count;
    assign base_mod      = ADDR_W'(32'(base_add) % DEPTH);

    assign pop       = m_valid & m_ready;
    assign push      = inflight;
    // Words already owned (buffered + in flight), net of this cycle's pop, must leave room.
    assign credit_ok = ((3'(occ) + 3'(inflight)) - 3'(pop)) < 3'd2;
    assign rd_en     = (state == RUN) && (issued < cmd_cnt) && credit_ok;
    assign rd_add    = ptr;
    assign m_valid   = (occ != 2'd0);

    // Command FSM, read pointer and in-flight tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            cmd_cnt       <= '0;
            issued        <= '0;
            ptr           <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight      <= rd_en;
            inflight_last <= rd_en && (issued == (cmd_cnt - CNT_W'(1)));

            if (rd_en) begin
                issued <= issued + CNT_W'(1);
                ptr    <= (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + ADDR_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (count_clamped == '0) begin
                            done <= 1'b1;
                        end else begin
                            state   <= RUN;
                            busy    <= 1'b1;
                            cmd_cnt <= count_clamped;
                            issued  <= '0;
                            ptr     <= base_mod;
                        end
                    end
                end
                RUN: begin
                    if (rd_en && ((issued + CNT_W'(1)) == cmd_cnt)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Two-entry output buffer; the head entry drives the stream directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= 2'd0;
            m_data   <= '0;
            m_last   <= 1'b0;
            buf_data <= '0;
            buf_last <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        m_data <= rd_data;
                        m_last <= inflight_last;
                    end else begin
                        buf_data <= rd_data;
                        buf_last <= inflight_last;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    m_data <= buf_data;
                    m_last <= buf_last;
                    occ    <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        m_data <= rd_data;
                        m_last <= inflight_last;
                    end else begin
                        m_data   <= buf_data;
                        m_last   <= buf_last;
                        buf_data <= rd_data;
                        buf_last <= inflight_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
